// File: rtl/me_blt_ctl_pkg.sv
// Shared game constants and helpers: screen geometry, coordinate and RGB333 pixel types.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package me_blt_ctl_pkg;

  localparam int SCR_W   = 640;
  localparam int SCR_H   = 480;
  localparam int COORD_W = 10;
  localparam int RGB_W   = 9;

  localparam logic [RGB_W-1:0] PIX_TRANSPARENT = '0;

  // True when lo <= pos < lo + len. The compare is done one bit wider than a
  // coordinate so a sprite near the right/bottom edge never wraps back to 0.
  function automatic logic in_span(input logic [COORD_W-1:0] pos,
                                   input logic [COORD_W-1:0] lo,
                                   input int                 len);
    logic [COORD_W:0] p;
    logic [COORD_W:0] l;
    p = {1'b0, pos};
    l = {1'b0, lo};
    return (p >= l) && (p < l + (COORD_W + 1)'(len));
  endfunction

endpackage

// File: rtl/me_blt_ctl_blt_slot.sv
// One player-bullet slot: position state, upward move, kill, spawn load and scan hit test.
// Latency: state updates on the clk edge; hit is combinational from current state and scan position.
// Backpressure: none; kill and move requests are always accepted on the edge they arrive.
module blt_slot
  import me_blt_ctl_pkg::*;
#(
  parameter int BLT_W = 4,
  parameter int BLT_H = 8,
  parameter int SPEED = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               clear,
  input  logic               spawn,
  input  logic [COORD_W-1:0] spawn_x,
  input  logic [COORD_W-1:0] spawn_y,
  input  logic [COORD_W-1:0] h_cnt,
  input  logic [COORD_W-1:0] v_cnt,
  output logic               active,
  output logic               hit
);

  localparam logic [COORD_W-1:0] STEP = COORD_W'(SPEED);

  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;

  // Live slot: kill beats move; a bullet that cannot move a full step leaves the top.
  // Idle slot: only a spawn can load it, and kills aimed at it are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else if (active) begin
      if (clear) begin
        active <= 1'b0;
      end else if (frame_tick) begin
        if (y < STEP) begin
          active <= 1'b0;
        end else begin
          y <= y - STEP;
        end
      end
    end else if (spawn) begin
      active <= 1'b1;
      x      <= spawn_x;
      y      <= spawn_y;
    end
  end

  assign hit = active && in_span(h_cnt, x, BLT_W) && in_span(v_cnt, y, BLT_H);

endmodule

// File: rtl/me_blt_ctl.sv
// Player bullet controller: fire request/cooldown, spawn arbitration over N_BLT slots, bullet pixel output.
// Latency: me_blt_pixel is 1 clk after h_cnt/v_cnt/valid; blt_active comes straight from slot flops.
// Backpressure: none; fire requests that cannot be served on a frame tick are dropped.
module me_blt_ctl
  import me_blt_ctl_pkg::*;
#(
  parameter int               N_BLT     = 4,
  parameter int               BLT_W     = 4,
  parameter int               BLT_H     = 8,
  parameter int               SPEED     = 4,
  parameter int               COOLDOWN  = 8,
  parameter logic [RGB_W-1:0] BLT_COLOR = 9'h1F8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               fire,
  input  logic [COORD_W-1:0] me_x,
  input  logic [COORD_W-1:0] me_y,
  input  logic [COORD_W-1:0] h_cnt,
  input  logic [COORD_W-1:0] v_cnt,
  input  logic               valid,
  input  logic [N_BLT-1:0]   hit_clear,
  output logic [N_BLT-1:0]   blt_active,
  output logic [RGB_W-1:0]   me_blt_pixel
);

  localparam int                 CD_W      = $clog2(COOLDOWN + 2);
  localparam logic [CD_W-1:0]    CD_RELOAD = CD_W'(COOLDOWN);
  localparam logic [COORD_W-1:0] SPAWN_DX  = COORD_W'(6);
  localparam logic [COORD_W-1:0] SPAWN_DY  = COORD_W'(BLT_H);

  logic                fire_req;
  logic                spawn_ok;
  logic [CD_W-1:0]     cooldown;
  logic [N_BLT-1:0]    spawn_sel;
  logic [N_BLT-1:0]    hit;
  logic [COORD_W-1:0]  spawn_x;
  logic [COORD_W-1:0]  spawn_y;

  // A press on the tick cycle itself is served by that tick.
  // Spawning is blocked when the bullet would start above the top edge.
  assign spawn_ok = frame_tick && (fire_req || fire) && (cooldown == '0) && (me_y >= SPAWN_DY);
  assign spawn_x  = me_x + SPAWN_DX;
  assign spawn_y  = me_y - SPAWN_DY;

  // Lowest-index idle slot as a one-hot (isolate lowest zero bit); uses start-of-cycle
  // flags, so slots freed on this tick are not reused until the next one.
  assign spawn_sel = spawn_ok ? (~blt_active & (blt_active + N_BLT'(1))) : '0;

  // Sticky fire request and shot cooldown; every tick consumes the request, served or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_req <= 1'b0;
      cooldown <= '0;
    end else if (frame_tick) begin
      fire_req <= 1'b0;
      if (|spawn_sel) begin
        cooldown <= CD_RELOAD;
      end else if (cooldown != '0) begin
        cooldown <= cooldown - CD_W'(1);
      end
    end else if (fire) begin
      fire_req <= 1'b1;
    end
  end

  for (genvar i = 0; i < N_BLT; i++) begin : g_slot
    blt_slot #(
      .BLT_W (BLT_W),
      .BLT_H (BLT_H),
      .SPEED (SPEED)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .clear      (hit_clear[i]),
      .spawn      (spawn_sel[i]),
      .spawn_x    (spawn_x),
      .spawn_y    (spawn_y),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .active     (blt_active[i]),
      .hit        (hit[i])
    );
  end

  // Registered pixel: bullet colour wherever any live bullet covers a visible scan position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      me_blt_pixel <= PIX_TRANSPARENT;
    end else begin
      me_blt_pixel <= (valid && (|hit)) ? BLT_COLOR : PIX_TRANSPARENT;
    end
  end

endmodule

// File: tb/tb_me_blt_ctl.sv
// Self-checking bench for me_blt_ctl: directed table, corner sequences, random run vs. behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_me_blt_ctl;

  localparam int N  = 4;
  localparam int BW = 4;
  localparam int BH = 8;
  localparam int SP = 4;
  localparam int CD = 8;
  localparam logic [8:0] COLOR = 9'h1F8;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       fire;
  logic       valid;
  logic [9:0] me_x;
  logic [9:0] me_y;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [N-1:0] hit_clear;
  logic [N-1:0] blt_active;
  logic [8:0]   me_blt_pixel;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model: a list of bullets with integer screen coordinates.
  bit         m_act [N];
  int         m_x   [N];
  int         m_y   [N];
  int         m_cd;
  bit         m_req;
  logic [8:0] exp_pix;

  always #5 clk = ~clk;

  me_blt_ctl #(
    .N_BLT     (N),
    .BLT_W     (BW),
    .BLT_H     (BH),
    .SPEED     (SP),
    .COOLDOWN  (CD),
    .BLT_COLOR (COLOR)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .fire         (fire),
    .me_x         (me_x),
    .me_y         (me_y),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .valid        (valid),
    .hit_clear    (hit_clear),
    .blt_active   (blt_active),
    .me_blt_pixel (me_blt_pixel)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [N-1:0] m_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_act[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 1'b0;
      m_x[i]   = 0;
      m_y[i]   = 0;
    end
    m_cd  = 0;
    m_req = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int  h;
    int  v;
    int  free_slot;
    bit  want;
    h = int'(h_cnt);
    v = int'(v_cnt);
    exp_pix = 9'h000;
    if (valid) begin
      for (int i = 0; i < N; i++)
        if (m_act[i] && m_x[i] <= h && h < m_x[i] + BW && m_y[i] <= v && v < m_y[i] + BH)
          exp_pix = COLOR;
    end
    free_slot = -1;
    for (int i = 0; i < N; i++)
      if (!m_act[i] && free_slot < 0) free_slot = i;
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        if (hit_clear[i]) m_act[i] = 1'b0;
        else if (frame_tick) begin
          if (m_y[i] < SP) m_act[i] = 1'b0;
          else m_y[i] = m_y[i] - SP;
        end
      end
    end
    if (frame_tick) begin
      want = m_req || fire;
      if (want && m_cd == 0 && free_slot >= 0 && int'(me_y) >= BH) begin
        m_act[free_slot] = 1'b1;
        m_x[free_slot]   = (int'(me_x) + 6) % 1024;
        m_y[free_slot]   = int'(me_y) - BH;
        m_cd = CD;
      end else if (m_cd > 0) begin
        m_cd = m_cd - 1;
      end
      m_req = 1'b0;
    end else if (fire) begin
      m_req = 1'b1;
    end
  endtask

  // One clock: model step, edge, then compare outputs 1 time unit after the edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("model_active", 32'(blt_active), 32'(m_vec()));
    chk("model_pixel", 32'(me_blt_pixel), 32'(exp_pix));
  endtask

  task automatic tick_pulse();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_tick = 1'b0;
    fire = 1'b0;
    hit_clear = '0;
    valid = 1'b0;
    h_cnt = '0;
    v_cnt = '0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_active", 32'(blt_active), 32'h0);
    chk("rst_pixel", 32'(me_blt_pixel), 32'h0);
    rst = 1'b0;
  endtask

  typedef struct {
    bit         fire;
    bit         tick;
    int         h;
    int         v;
    bit         vld;
    logic [3:0] e_act;
    logic [8:0] e_pix;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b1, 1'b0,   0,   0, 1'b1, 4'b0000, 9'h000};
    tbl[1] = '{1'b0, 1'b1,   0,   0, 1'b1, 4'b0001, 9'h000};
    tbl[2] = '{1'b0, 1'b0, 106, 392, 1'b1, 4'b0001, 9'h1F8};
    tbl[3] = '{1'b0, 1'b0, 110, 392, 1'b1, 4'b0001, 9'h000};
    tbl[4] = '{1'b0, 1'b0, 109, 399, 1'b1, 4'b0001, 9'h1F8};
    tbl[5] = '{1'b0, 1'b0, 109, 400, 1'b1, 4'b0001, 9'h000};
    tbl[6] = '{1'b0, 1'b0, 105, 395, 1'b1, 4'b0001, 9'h000};
    tbl[7] = '{1'b0, 1'b0, 106, 391, 1'b1, 4'b0001, 9'h000};
    tbl[8] = '{1'b0, 1'b0, 107, 395, 1'b0, 4'b0001, 9'h000};
    tbl[9] = '{1'b0, 1'b0, 107, 395, 1'b1, 4'b0001, 9'h1F8};

    me_x = 10'd100;
    me_y = 10'd400;
    do_reset();

    // First shot and its footprint
    for (int i = 0; i < 10; i++) begin
      fire       = tbl[i].fire;
      frame_tick = tbl[i].tick;
      h_cnt      = 10'(tbl[i].h);
      v_cnt      = 10'(tbl[i].v);
      valid      = tbl[i].vld;
      cyc();
      chk($sformatf("vec%0d_active", i), 32'(blt_active), 32'(tbl[i].e_act));
      chk($sformatf("vec%0d_pixel", i), 32'(me_blt_pixel), 32'(tbl[i].e_pix));
    end
    frame_tick = 1'b0;

    // Held fire: cooldown blocks 8 ticks, 9th tick spawns into slot1
    fire  = 1'b1;
    valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick_pulse();
      chk("cooldown_hold", 32'(blt_active), 32'h1);
    end
    fire = 1'b0; valid = 1'b1; h_cnt = 10'd106; v_cnt = 10'd360;
    cyc();
    chk("slot0_at_360", 32'(me_blt_pixel), 32'(COLOR));
    v_cnt = 10'd359;
    cyc();
    chk("slot0_above_360", 32'(me_blt_pixel), 32'h0);
    fire = 1'b1;
    tick_pulse();
    chk("spawn_tick9", 32'(blt_active), 32'h3);
    fire = 1'b0; v_cnt = 10'd392;
    cyc();
    chk("slot1_at_392", 32'(me_blt_pixel), 32'(COLOR));
    v_cnt = 10'd356;
    cyc();
    chk("slot0_at_356", 32'(me_blt_pixel), 32'(COLOR));

    // Request during cooldown is discarded, not carried
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    for (int k = 0; k < 10; k++) tick_pulse();
    chk("discard_in_cooldown", 32'(blt_active), 32'h3);

    // Off the top: y=2 leaves on the next tick
    do_reset();
    me_x = 10'd0; me_y = 10'd10; fire = 1'b1;
    tick_pulse();
    fire = 1'b0; valid = 1'b1; h_cnt = 10'd6; v_cnt = 10'd2;
    cyc();
    chk("y2_visible", 32'(me_blt_pixel), 32'(COLOR));
    tick_pulse();
    chk("y2_gone_active", 32'(blt_active), 32'h0);
    cyc();
    chk("y2_gone_pixel", 32'(me_blt_pixel), 32'h0);

    // y equal to SPEED moves to 0 and stays alive one more tick
    do_reset();
    me_y = 10'd12; fire = 1'b1;
    tick_pulse();
    fire = 1'b0;
    tick_pulse();
    chk("y4_to_0_alive", 32'(blt_active), 32'h1);
    valid = 1'b1; h_cnt = 10'd6; v_cnt = 10'd0;
    cyc();
    chk("y0_pixel", 32'(me_blt_pixel), 32'(COLOR));
    tick_pulse();
    chk("y0_gone", 32'(blt_active), 32'h0);

    // Player too high to fire; request consumed anyway
    do_reset();
    me_y = 10'd7; fire = 1'b1;
    cyc();
    fire = 1'b0;
    tick_pulse();
    chk("suppress_high", 32'(blt_active), 32'h0);
    me_y = 10'd8;
    tick_pulse();
    chk("suppress_req_cleared", 32'(blt_active), 32'h0);
    fire = 1'b1;
    tick_pulse();
    chk("spawn_at_y0", 32'(blt_active), 32'h1);

    // All slots full; a slot killed on a tick is not reused until the next tick
    do_reset();
    me_x = 10'd200; me_y = 10'd400; fire = 1'b1;
    for (int k = 0; k < 36; k++) tick_pulse();
    chk("all_full", 32'(blt_active), 32'hF);
    hit_clear = 4'b0001; frame_tick = 1'b1;
    cyc();
    hit_clear = '0; frame_tick = 1'b0;
    chk("clear_no_respawn", 32'(blt_active), 32'hE);
    cyc();
    tick_pulse();
    chk("respawn_slot0", 32'(blt_active), 32'hF);
    hit_clear = 4'b0100;
    cyc();
    hit_clear = '0;
    chk("clear_between_ticks", 32'(blt_active), 32'hB);

    // Asynchronous reset with three bullets in flight
    do_reset();
    me_y = 10'd400; fire = 1'b1;
    for (int k = 0; k < 19; k++) tick_pulse();
    chk("three_live", 32'(blt_active), 32'h7);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_active", 32'(blt_active), 32'h0);
    chk("async_rst_pixel", 32'(me_blt_pixel), 32'h0);
    model_reset();
    fire = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    tick_pulse();
    chk("first_tick_after_rst", 32'(blt_active), 32'h1);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int s;
      frame_tick = ($urandom_range(0, 3) == 0);
      fire       = ($urandom_range(0, 2) == 0);
      valid      = ($urandom_range(0, 7) != 0);
      me_x       = 10'($urandom_range(0, 639));
      me_y       = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 10)) : 10'($urandom_range(0, 479));
      for (int b = 0; b < N; b++) hit_clear[b] = ($urandom_range(0, 7) == 0);
      s = $urandom_range(0, N - 1);
      if (m_act[s] && $urandom_range(0, 1) == 1) begin
        h_cnt = 10'(m_x[s] + int'($urandom_range(0, BW + 1)) - 1);
        v_cnt = 10'(m_y[s] + int'($urandom_range(0, BH + 1)) - 1);
      end else begin
        h_cnt = 10'($urandom_range(0, 1023));
        v_cnt = 10'($urandom_range(0, 1023));
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
